// File: rtl/spike_det_pkg.sv
// Shared types and defaults for the spike run detector.
package spike_det_pkg;

  localparam int DATA_W  = 12;
  localparam int MIN_RUN = 3;
  localparam int MAX_GAP = 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StGap     = 3'd2,
    StSpike   = 3'd3,
    StRefract = 3'd4
  } spike_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module spike_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_run_detector.sv
// Run-length spike detector with gap tolerance, hysteresis release and event pulses.
// Optional refractory period after each spike is enabled by defining SPIKE_REFRACT_EN.
module spike_run_detector #(
  parameter int DATA_W      = spike_det_pkg::DATA_W,
  parameter int MIN_RUN     = spike_det_pkg::MIN_RUN,
  parameter int MAX_GAP     = spike_det_pkg::MAX_GAP,
  parameter int CNT_W       = 16,
  parameter int REFRACT_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     q_valid,
  input  logic signed [DATA_W-1:0] q,
  input  logic signed [DATA_W-1:0] thr_hi,
  input  logic signed [DATA_W-1:0] thr_lo,
  output logic                     spike,
  output logic                     spike_start,
  output logic                     spike_end,
  output logic [CNT_W-1:0]         spike_cnt
);

  import spike_det_pkg::spike_state_t, spike_det_pkg::cnt_width;
  import spike_det_pkg::StIdle, spike_det_pkg::StArm, spike_det_pkg::StGap, spike_det_pkg::StSpike;
`ifdef SPIKE_REFRACT_EN
  import spike_det_pkg::StRefract;
`endif

  localparam int RUN_W = cnt_width(MIN_RUN);
  localparam int GAP_W = cnt_width(MAX_GAP);

  if (MIN_RUN < 1 || MAX_GAP < 0 || REFRACT_LEN < 1) begin : g_bad_param
    $error("spike_run_detector: illegal parameter value");
  end

  spike_state_t     state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             spike_start_q, spike_start_d;
  logic             spike_end_q, spike_end_d;
  logic             hit, hold_spike, enter_spike;
  logic             run_done;
  spike_state_t     release_st;

  assign hit        = (q >= thr_hi);
  assign hold_spike = (q >= thr_lo);
  assign run_inc    = run_q + 1'b1;
  assign run_done   = (run_inc == RUN_W'(MIN_RUN));

`ifdef SPIKE_REFRACT_EN
  localparam int REFR_W = cnt_width(REFRACT_LEN);
  logic [REFR_W-1:0] refr_q, refr_d;
  assign release_st = StRefract;
`else
  assign release_st = StIdle;
`endif

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    gap_d   = gap_q;
`ifdef SPIKE_REFRACT_EN
    refr_d  = refr_q;
`endif
    if (q_valid) begin
      case (state_q)
        StIdle: begin
          if (hit) begin
            if (MIN_RUN == 1) begin
              state_d = StSpike;
            end else begin
              state_d = StArm;
              run_d   = RUN_W'(1);
            end
          end
        end
        StArm: begin
          if (hit) begin
            run_d   = run_inc;
            state_d = run_done ? StSpike : StArm;
          end else if (MAX_GAP == 0) begin
            state_d = StIdle;
            run_d   = '0;
          end else begin
            state_d = StGap;
            gap_d   = GAP_W'(1);
          end
        end
        StGap: begin
          // Gap samples never add to the run; a hit resumes counting where it stopped.
          if (hit) begin
            run_d   = run_inc;
            gap_d   = '0;
            state_d = run_done ? StSpike : StArm;
          end else if (gap_q == GAP_W'(MAX_GAP)) begin
            state_d = StIdle;
            run_d   = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        StSpike: begin
          if (!hold_spike) begin
            state_d = release_st;
            run_d   = '0;
            gap_d   = '0;
          end
        end
`ifdef SPIKE_REFRACT_EN
        StRefract: begin
          if (refr_q == REFR_W'(REFRACT_LEN - 1)) begin
            state_d = StIdle;
            refr_d  = '0;
          end else begin
            refr_d = refr_q + 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  assign enter_spike   = q_valid && (state_d == StSpike) && (state_q != StSpike);
  assign spike_start_d = enter_spike;
  assign spike_end_d   = q_valid && (state_q == StSpike) && (state_d != StSpike);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      run_q         <= '0;
      gap_q         <= '0;
      spike_start_q <= 1'b0;
      spike_end_q   <= 1'b0;
`ifdef SPIKE_REFRACT_EN
      refr_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      gap_q         <= gap_d;
      spike_start_q <= spike_start_d;
      spike_end_q   <= spike_end_d;
`ifdef SPIKE_REFRACT_EN
      refr_q        <= refr_d;
`endif
    end
  end

  spike_sat_counter #(
    .Width(CNT_W)
  ) u_spike_cnt (
    .clk  (clk),
    .clr_i(rst),
    .inc_i(enter_spike && !rst),
    .cnt_o(spike_cnt)
  );

  assign spike       = (state_q == StSpike);
  assign spike_start = spike_start_q;
  assign spike_end   = spike_end_q;

endmodule
